// File: rtl/mux_pkg.sv
// Shared constants and helpers for the lane-select mux family.
// Default geometry is 8 lanes of 1 bit.
package mux_pkg;

   localparam int DEF_LANES  = 8;
   localparam int DEF_DATA_W = 1;

   // Select width for a given lane count, never narrower than one bit
   function automatic int sel_width(input int lanes);
      int w;
      w = $clog2(lanes);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int DEF_SEL_W = sel_width(DEF_LANES);

   // Lane extract for a default-geometry bus; lane k sits at [k*DATA_W +: DATA_W]
   function automatic logic [DEF_DATA_W-1:0] lane_of(
      input logic [DEF_LANES*DEF_DATA_W-1:0] bus,
      input logic [DEF_SEL_W-1:0]            idx
   );
      logic [DEF_LANES-1:0][DEF_DATA_W-1:0] lanes;
      lanes = bus;
      return lanes[idx];
   endfunction

endpackage

// File: rtl/mux_sel_decode.sv
// One-hot decode of the lane select plus out-of-range flag.
// Decode is forced to all-zero whenever the select is out of range.
module mux_sel_decode
   import mux_pkg::*;
#(
   parameter int  LANES = DEF_LANES,
   localparam int SEL_W = sel_width(LANES)
) (
   input  logic [SEL_W-1:0] sel,
   output logic [LANES-1:0] sel_oh,
   output logic             sel_err
);

   logic [LANES-1:0] hit_s;
   logic             range_err_s;

   // Per-lane equality compare
   generate
      for (genvar k = 0; k < LANES; k++) begin : g_hit
         assign hit_s[k] = (sel == SEL_W'(k));
      end
   endgenerate

   // Widen by one bit so LANES itself is representable
   assign range_err_s = ({1'b0, sel} >= (SEL_W+1)'(LANES));

   // Gate the decode with the range check
   always_comb begin
      sel_err = range_err_s;
      if (range_err_s) begin
         sel_oh = '0;
      end else begin
         sel_oh = hit_s;
      end
   end

endmodule

// File: rtl/mux_8to1.sv
// Lane-select mux: combinational selected lane plus a registered capture
// stage (y_q/sel_q/y_vld) for downstream synchronous logic.
module mux_8to1
   import mux_pkg::*;
#(
   parameter int  LANES  = DEF_LANES,
   parameter int  DATA_W = DEF_DATA_W,
   localparam int SEL_W  = sel_width(LANES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [LANES*DATA_W-1:0]   in,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      en,
   output logic [DATA_W-1:0]         y,
   output logic                      sel_err,
   output logic [LANES-1:0]          sel_oh,
   output logic [DATA_W-1:0]         y_q,
   output logic [SEL_W-1:0]          sel_q,
   output logic                      y_vld
);

   logic [LANES-1:0][DATA_W-1:0] lanes_s;
   logic [LANES-1:0]             sel_oh_s;
   logic                         sel_err_s;
   logic [DATA_W-1:0]            y_s;
   logic [DATA_W-1:0]            y_q_r;
   logic [SEL_W-1:0]             sel_q_r;
   logic                         y_vld_r;

   assign lanes_s = in;

   mux_sel_decode #(
      .LANES (LANES)
   ) u_decode (
      .sel     (sel),
      .sel_oh  (sel_oh_s),
      .sel_err (sel_err_s)
   );

   // Selected lane, forced to zero for an out-of-range select
   always_comb begin
      if (sel_err_s) begin
         y_s = '0;
      end else begin
         y_s = lanes_s[sel];
      end
   end

   // Capture stage; valid strobe lasts exactly one cycle per capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q_r   <= '0;
         sel_q_r <= '0;
         y_vld_r <= 1'b0;
      end else if (en) begin
         y_q_r   <= y_s;
         sel_q_r <= sel;
         y_vld_r <= 1'b1;
      end else begin
         y_vld_r <= 1'b0;
      end
   end

   assign y       = y_s;
   assign sel_err = sel_err_s;
   assign sel_oh  = sel_oh_s;
   assign y_q     = y_q_r;
   assign sel_q   = sel_q_r;
   assign y_vld   = y_vld_r;

endmodule

// File: tb/tb_mux_8to1.sv
// Directed self-checking bench for mux_8to1: default 8x1 build plus a
// 6-lane, 4-bit-wide build for the out-of-range select cases.
module tb_mux_8to1;

   logic        clk;
   logic        rst;
   logic [7:0]  in;
   logic [2:0]  sel;
   logic        en;
   logic        y;
   logic        sel_err;
   logic [7:0]  sel_oh;
   logic        y_q;
   logic [2:0]  sel_q;
   logic        y_vld;

   logic [23:0] in_p6;
   logic [2:0]  sel_p6;
   logic        en_p6;
   logic [3:0]  y_p6;
   logic        err_p6;
   logic [5:0]  oh_p6;
   logic [3:0]  yq_p6;
   logic [2:0]  selq_p6;
   logic        vld_p6;

   int n_tests;
   int n_fail;

   mux_8to1 u_dut (
      .clk     (clk),
      .rst     (rst),
      .in      (in),
      .sel     (sel),
      .en      (en),
      .y       (y),
      .sel_err (sel_err),
      .sel_oh  (sel_oh),
      .y_q     (y_q),
      .sel_q   (sel_q),
      .y_vld   (y_vld)
   );

   mux_8to1 #(
      .LANES  (6),
      .DATA_W (4)
   ) u_dut_p6 (
      .clk     (clk),
      .rst     (rst),
      .in      (in_p6),
      .sel     (sel_p6),
      .en      (en_p6),
      .y       (y_p6),
      .sel_err (err_p6),
      .sel_oh  (oh_p6),
      .y_q     (yq_p6),
      .sel_q   (selq_p6),
      .y_vld   (vld_p6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_y;
      logic [7:0] pats [3];
      logic [7:0] pat;
      logic [7:0] chg_in  [3];
      logic [2:0] chg_sel [3];
      logic [2:0] chg_y;
      logic [3:0] exp_p6  [6];

      n_tests = 0;
      n_fail  = 0;
      rst    = 1'b1;
      en     = 1'b0;
      in     = 8'h00;
      sel    = 3'd0;
      in_p6  = 24'h000000;
      sel_p6 = 3'd0;
      en_p6  = 1'b0;

      #2;
      check("rst_y_q",     32'(y_q),     32'd0);
      check("rst_sel_q",   32'(sel_q),   32'd0);
      check("rst_y_vld",   32'(y_vld),   32'd0);
      check("rst_p6_y_q",  32'(yq_p6),   32'd0);
      check("rst_p6_vld",  32'(vld_p6),  32'd0);
      check("rst_p6_selq", 32'(selq_p6), 32'd0);
      #1 rst = 1'b0;

      // alternating pattern, combinational sweep
      in    = 8'b1010_1010;
      exp_y = 8'b1010_1010;
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         #1;
         check("alt_y",   32'(y),       32'(exp_y[i]));
         check("alt_oh",  32'(sel_oh),  32'h1 << i);
         check("alt_err", 32'(sel_err), 32'd0);
         #9;
      end

      // lane 0 / lane 7 ordering and all-ones
      pats[0] = 8'h01;
      pats[1] = 8'h80;
      pats[2] = 8'hFF;
      for (int p = 0; p < 3; p++) begin
         pat = pats[p];
         in  = pat;
         for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1 check("sweep_y", 32'(y), 32'(pat[i]));
         end
      end

      // capture something non-zero, then pulse reset mid-cycle
      @(negedge clk);
      in  = 8'hFF;
      sel = 3'd5;
      en  = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check("cap0_y_q",   32'(y_q),   32'd1);
      check("cap0_sel_q", 32'(sel_q), 32'd5);
      #2 rst = 1'b1;
      #1;
      check("async_rst_y_q",   32'(y_q),   32'd0);
      check("async_rst_sel_q", 32'(sel_q), 32'd0);
      check("async_rst_y",     32'(y),     32'd1);
      #1 rst = 1'b0;

      // single capture of lane 3 of 0xAA
      @(negedge clk);
      in  = 8'hAA;
      sel = 3'd3;
      en  = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check("cap_y_q",   32'(y_q),   32'd1);
      check("cap_sel_q", 32'(sel_q), 32'd3);
      check("cap_vld",   32'(y_vld), 32'd1);

      // hold for 3 clocks while inputs change
      chg_in[0] = 8'h00; chg_sel[0] = 3'd3;
      chg_in[1] = 8'h55; chg_sel[1] = 3'd2;
      chg_in[2] = 8'h0F; chg_sel[2] = 3'd6;
      chg_y     = 3'b010;
      for (int j = 0; j < 3; j++) begin
         in  = chg_in[j];
         sel = chg_sel[j];
         #1 check("hold_y", 32'(y), 32'(chg_y[j]));
         @(negedge clk);
         check("hold_y_q",   32'(y_q),   32'd1);
         check("hold_sel_q", 32'(sel_q), 32'd3);
         check("hold_vld",   32'(y_vld), 32'd0);
      end

      // reset asserted across an enabled edge with y=1
      in  = 8'hFF;
      sel = 3'd6;
      en  = 1'b1;
      #3 rst = 1'b1;
      @(negedge clk);
      check("rst_win_y_q", 32'(y_q),   32'd0);
      check("rst_win_vld", 32'(y_vld), 32'd0);
      check("rst_win_y",   32'(y),     32'd1);

      // first capture after release
      rst = 1'b0;
      in  = 8'h80;
      sel = 3'd7;
      @(negedge clk);
      en = 1'b0;
      check("rel_y_q",   32'(y_q),   32'd1);
      check("rel_sel_q", 32'(sel_q), 32'd7);
      check("rel_vld",   32'(y_vld), 32'd1);
      @(negedge clk);
      check("rel_vld_drop", 32'(y_vld), 32'd0);

      // 6 lanes x 4 bits: lanes 0..5 = 1,8,C,3,A,5
      in_p6 = 24'h5A3C81;
      exp_p6[0] = 4'h1; exp_p6[1] = 4'h8; exp_p6[2] = 4'hC;
      exp_p6[3] = 4'h3; exp_p6[4] = 4'hA; exp_p6[5] = 4'h5;
      for (int i = 0; i < 6; i++) begin
         sel_p6 = 3'(i);
         #1;
         check("p6_y",   32'(y_p6),   32'(exp_p6[i]));
         check("p6_oh",  32'(oh_p6),  32'h1 << i);
         check("p6_err", 32'(err_p6), 32'd0);
      end
      for (int i = 6; i < 8; i++) begin
         sel_p6 = 3'(i);
         #1;
         check("p6_oor_y",   32'(y_p6),   32'd0);
         check("p6_oor_oh",  32'(oh_p6),  32'd0);
         check("p6_oor_err", 32'(err_p6), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
